// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared constants, FSM state type and pixel conversion helpers
// for the OV7670 capture block and its frame-buffer neighbours.
//   H_ACTIVE / V_ACTIVE : camera geometry before 2:1 decimation
//   FB_DEPTH / ADDR_W   : shared 320x240 frame buffer and its address width
//   PIX_W               : stored pixel width {R,G,B} 4 bits each
package ov7670_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int FB_DEPTH = 76800;
   localparam int ADDR_W   = 17;
   localparam int PIX_W    = 12;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      BLANK     = 2'd1,
      ACTIVE    = 2'd2
   } cap_state_t;

   // hi = RRRRRGGG, lo = GGGBBBBB; keep the top 4 bits of each field.
   function automatic logic [PIX_W-1:0] rgb565_to_444(input logic [7:0] hi,
                                                      input logic [7:0] lo);
      return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
   endfunction

   // Y = (R5 + 2*G6[5:1] + B5) >> 3, replicated into all three channels.
   function automatic logic [PIX_W-1:0] rgb565_to_gray(input logic [7:0] hi,
                                                       input logic [7:0] lo);
      logic [6:0] sum;
      logic [3:0] y;
      sum = {2'b00, hi[7:3]} + {1'b0, hi[2:0], lo[7:6], 1'b0} + {2'b00, lo[4:0]};
      y   = sum[6:3];
      return {y, y, y};
   endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if: camera parallel bus plus frame-buffer write port.
//   master : camera/source side (drives cam_*, observes fb_* and frame_done)
//   slave  : capture block side (samples cam_*, drives fb_* and frame_done)
interface ov7670_capture_if #(
   parameter int ADDR_W = ov7670_pkg::ADDR_W
);
   import ov7670_pkg::*;

   logic              cam_vsync;
   logic              cam_href;
   logic [7:0]        cam_d;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [PIX_W-1:0]  fb_data;
   logic              frame_done;

   modport master (
      output cam_vsync, cam_href, cam_d,
      input  fb_we, fb_addr, fb_data, frame_done
   );

   modport slave (
      input  cam_vsync, cam_href, cam_d,
      output fb_we, fb_addr, fb_data, frame_done
   );

endinterface

// File: rtl/ov7670_capture_cam_sync_edge.sv
// cam_sync_edge: registers the camera bus once on pclk and keeps a second
// delayed copy of vsync/href for edge detection.
//   i_vsync/i_href/i_d : raw camera inputs
//   o_vsync/o_href/o_d : registered copies used for all decisions
//   o_vs_rise/o_vs_fall/o_hr_fall : single-cycle edge flags
module cam_sync_edge (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       i_vsync,
   input  logic       i_href,
   input  logic [7:0] i_d,
   output logic       o_vsync,
   output logic       o_href,
   output logic [7:0] o_d,
   output logic       o_vs_rise,
   output logic       o_vs_fall,
   output logic       o_hr_fall
);

   logic       r_vs1, r_vs2;
   logic       r_hr1, r_hr2;
   logic [7:0] r_d1;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs1 <= 1'b0;
         r_vs2 <= 1'b0;
         r_hr1 <= 1'b0;
         r_hr2 <= 1'b0;
         r_d1  <= 8'h00;
      end else begin
         r_vs1 <= i_vsync;
         r_vs2 <= r_vs1;
         r_hr1 <= i_href;
         r_hr2 <= r_hr1;
         r_d1  <= i_d;
      end
   end

   assign o_vsync   = r_vs1;
   assign o_href    = r_hr1;
   assign o_d       = r_d1;
   assign o_vs_rise = r_vs1 & ~r_vs2;
   assign o_vs_fall = ~r_vs1 & r_vs2;
   assign o_hr_fall = ~r_hr1 & r_hr2;

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: samples the OV7670 RGB565 byte stream, decimates 2:1 in
// both axes and writes 12-bit pixels into the shared frame buffer.
//   pclk, rst_n : camera pixel clock, async active-low reset
//   bus (slave) : cam_vsync/cam_href/cam_d in; fb_we/fb_addr/fb_data and
//                 frame_done out
// Build option: define CAPTURE_GRAY_EN to store {Y,Y,Y} luma instead of RGB444.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_SYNC | after reset; skip the partial frame until a vsync rise
// BLANK     | vertical blanking; vsync fall restarts address/counters
// ACTIVE    | capturing lines; vsync rise ends the frame (frame_done)
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = ov7670_pkg::H_ACTIVE,
   parameter int V_ACTIVE = ov7670_pkg::V_ACTIVE,
   parameter int FB_DEPTH = ov7670_pkg::FB_DEPTH,
   parameter int ADDR_W   = ov7670_pkg::ADDR_W
) (
   input  logic               pclk,
   input  logic               rst_n,
   ov7670_capture_if.slave    bus
);

   localparam int COL_W = $clog2(H_ACTIVE) + 1;
   localparam int LINE_W = $clog2(V_ACTIVE) + 1;

   logic             w_vsync, w_href;
   logic [7:0]       w_d;
   logic             w_vs_rise, w_vs_fall, w_hr_fall;

   cap_state_t       r_state, w_next;
   logic             w_frame_start, w_frame_end;

   logic             r_phase;
   logic [7:0]       r_hi;
   logic [COL_W-1:0] r_col;
   logic [LINE_W-1:0] r_line;
   logic [ADDR_W:0]  r_wr_cnt;
   logic             w_full;
   logic [PIX_W-1:0] w_pix;

   logic             r_fb_we;
   logic [ADDR_W-1:0] r_fb_addr;
   logic [PIX_W-1:0] r_fb_data;
   logic             r_frame_done;

   cam_sync_edge u_sync (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .i_vsync   (bus.cam_vsync),
      .i_href    (bus.cam_href),
      .i_d       (bus.cam_d),
      .o_vsync   (w_vsync),
      .o_href    (w_href),
      .o_d       (w_d),
      .o_vs_rise (w_vs_rise),
      .o_vs_fall (w_vs_fall),
      .o_hr_fall (w_hr_fall)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) r_state <= WAIT_SYNC;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_frame_start = 1'b0;
      w_frame_end   = 1'b0;
      case (r_state)
         WAIT_SYNC: if (w_vs_rise) w_next = BLANK;
         BLANK: begin
            if (w_vs_fall) begin
               w_next        = ACTIVE;
               w_frame_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (w_vs_rise) begin
               w_next      = BLANK;
               w_frame_end = 1'b1;
            end
         end
         default: w_next = WAIT_SYNC;
      endcase
   end

   // Write count carries one extra bit so it can reach FB_DEPTH itself.
   assign w_full = (r_wr_cnt >= (ADDR_W+1)'(FB_DEPTH));

`ifdef CAPTURE_GRAY_EN
   assign w_pix = rgb565_to_gray(r_hi, w_d);
`else
   assign w_pix = rgb565_to_444(r_hi, w_d);
`endif

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase      <= 1'b0;
         r_hi         <= 8'h00;
         r_col        <= '0;
         r_line       <= '0;
         r_wr_cnt     <= '0;
         r_fb_we      <= 1'b0;
         r_fb_addr    <= '0;
         r_fb_data    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_fb_we      <= 1'b0;
         r_frame_done <= w_frame_end;
         if (w_frame_start) begin
            r_phase   <= 1'b0;
            r_col     <= '0;
            r_line    <= '0;
            r_wr_cnt  <= '0;
            r_fb_addr <= '0;
         end else if (r_state == ACTIVE && !w_vs_rise) begin
            if (w_href) begin
               if (!r_phase) begin
                  r_hi    <= w_d;
                  r_phase <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  r_col   <= r_col + 1'b1;
                  if (!r_col[0] && !r_line[0] && !w_full) begin
                     r_fb_we   <= 1'b1;
                     r_fb_data <= w_pix;
                     r_fb_addr <= r_wr_cnt[ADDR_W-1:0];
                     r_wr_cnt  <= r_wr_cnt + 1'b1;
                  end
               end
            end else begin
               r_phase <= 1'b0;
               r_col   <= '0;
            end
            if (w_hr_fall) r_line <= r_line + 1'b1;
         end else begin
            // Outside capture (or on a mid-line vsync rise) a half pixel is dropped.
            r_phase <= 1'b0;
         end
      end
   end

   assign bus.fb_we      = r_fb_we;
   assign bus.fb_addr    = r_fb_addr;
   assign bus.fb_data    = r_fb_data;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ov7670_capture.sv
module tb_ov7670_capture;
   import ov7670_pkg::*;

   localparam int TB_DEPTH = 12;
   localparam int AW       = 17;
   localparam int PPL      = 8;

`ifdef CAPTURE_GRAY_EN
   localparam logic [11:0] EXP_RED = 12'h333;
   localparam logic [11:0] EXP_GRN = 12'h777;
`else
   localparam logic [11:0] EXP_RED = 12'hF00;
   localparam logic [11:0] EXP_GRN = 12'h0F0;
`endif

   logic pclk = 1'b0;
   logic rst_n = 1'b0;

   ov7670_capture_if #(.ADDR_W(AW)) bus ();

   ov7670_capture #(
      .H_ACTIVE (16),
      .V_ACTIVE (20),
      .FB_DEPTH (TB_DEPTH),
      .ADDR_W   (AW)
   ) dut (
      .pclk  (pclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [11:0]   data;
   } exp_t;

   exp_t          sb_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            wr_count = 0;
   int            fd_count = 0;
   logic [AW-1:0] last_addr;
   logic [11:0]   last_data;
   logic [11:0]   mem [0:TB_DEPTH-1];

   bit m_synced = 0;
   bit m_active = 0;
   int m_line = 0;
   int m_cnt = 0;
   int exp_fd = 0;

   function automatic logic [11:0] exp_pix(input logic [15:0] p);
`ifdef CAPTURE_GRAY_EN
      int r, g, b, y;
      r = int'(p[15:11]);
      g = int'(p[10:5]);
      b = int'(p[4:0]);
      y = (r + 2 * (g / 2) + b) / 8;
      return {4'(y), 4'(y), 4'(y)};
`else
      return {p[15:12], p[10:7], p[4:1]};
`endif
   endfunction

   function automatic logic [15:0] gen(input int mode, input int line, input int col);
      logic [15:0] tab [0:7];
      tab = '{16'h07E0, 16'h001F, 16'hF800, 16'h1234,
              16'hFFFF, 16'h5A5A, 16'h8410, 16'hABCD};
      if (mode == 0) return 16'hF800;
      if (mode == 2 && col == 0) return 16'h8410;
      if (line == 0) return tab[col];
      return 16'(line * 16'h1111 + col * 16'h0321);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every DUT write is matched against the next expected entry.
   always @(negedge pclk) begin
      if (rst_n) begin
         if (bus.fb_we) begin
            exp_t e;
            wr_count++;
            last_addr = bus.fb_addr;
            last_data = bus.fb_data;
            if (int'(bus.fb_addr) < TB_DEPTH) mem[int'(bus.fb_addr)] = bus.fb_data;
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: addr=%0d data=%h, no write expected",
                        bus.fb_addr, bus.fb_data);
            end else begin
               e = sb_q.pop_front();
               if (bus.fb_addr !== e.addr || bus.fb_data !== e.data) begin
                  n_fail++;
                  $display("FAIL write: addr=%0d data=%h, expected addr=%0d data=%h",
                           bus.fb_addr, bus.fb_data, e.addr, e.data);
               end
            end
         end
         if (bus.frame_done) fd_count++;
      end
   end

   task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
      bus.cam_vsync = vs;
      bus.cam_href  = hr;
      bus.cam_d     = d;
      @(posedge pclk);
      #1;
   endtask

   task automatic send_line(input int mode);
      logic [15:0] p;
      for (int c = 0; c < PPL; c++) begin
         p = gen(mode, m_line, c);
         drive(1'b0, 1'b1, p[15:8]);
         drive(1'b0, 1'b1, p[7:0]);
         if (m_active && (m_line % 2 == 0) && (c % 2 == 0) && m_cnt < TB_DEPTH) begin
            sb_q.push_back('{addr: AW'(m_cnt), data: exp_pix(p)});
            m_cnt++;
         end
      end
      repeat (4) drive(1'b0, 1'b0, 8'h00);
      if (m_active) m_line++;
   endtask

   task automatic vs_pulse();
      if (m_active) exp_fd++;
      m_active = 0;
      m_synced = 1;
      repeat (6) drive(1'b1, 1'b0, 8'h00);
      m_active = m_synced;
      m_line   = 0;
      m_cnt    = 0;
      repeat (4) drive(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cam_vsync = 1'b0;
      bus.cam_href  = 1'b0;
      bus.cam_d     = 8'h00;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("reset_fb_we", 32'(bus.fb_we), 32'd0);
      check("reset_fb_addr", 32'(bus.fb_addr), 32'd0);
      check("reset_fb_data", 32'(bus.fb_data), 32'd0);
      check("reset_frame_done", 32'(bus.frame_done), 32'd0);
      @(posedge pclk);
      #1;
      rst_n = 1'b1;
      repeat (2) drive(1'b0, 1'b0, 8'h00);

      // Full (scaled) frame of pure red fills the buffer exactly.
      vs_pulse();
      wr_count = 0;
      repeat (6) send_line(0);
      check("red_writes", 32'(wr_count), 32'(TB_DEPTH));
      check("red_last_addr", 32'(last_addr), 32'(TB_DEPTH - 1));
      check("red_last_data", 32'(last_data), 32'(EXP_RED));
      vs_pulse();
      check("red_frame_done", 32'(fd_count), 32'(exp_fd));

      // Short frame with directed pixels; odd columns and lines dropped.
      wr_count = 0;
      repeat (2) send_line(1);
      check("dir_writes", 32'(wr_count), 32'd4);
      check("dir_mem0", 32'(mem[0]), 32'(EXP_GRN));
      check("dir_mem1_col2", 32'(mem[1]), 32'(EXP_RED));
      check("dir_mem2_ffff", 32'(mem[2]), 32'h0FFF);
      check("dir_mem3_8410", 32'(mem[3]), 32'h0888);
      vs_pulse();

      // Overlong frame: writes saturate, next frame restarts at 0.
      wr_count = 0;
      repeat (10) send_line(1);
      check("ovf_writes", 32'(wr_count), 32'(TB_DEPTH));
      check("ovf_addr_hold", 32'(bus.fb_addr), 32'(TB_DEPTH - 1));
      vs_pulse();
      check("ovf_addr_restart", 32'(bus.fb_addr), 32'd0);
      wr_count = 0;
      repeat (2) send_line(1);
      check("ovf_next_writes", 32'(wr_count), 32'd4);

      // Reset released mid-frame: frame skipped, capture resumes after vsync.
      vs_pulse();
      send_line(1);
      repeat (5) drive(1'b0, 1'b1, 8'h5A);
      rst_n    = 1'b0;
      m_synced = 0;
      m_active = 0;
      @(negedge pclk);
      check("midrst_fb_we", 32'(bus.fb_we), 32'd0);
      check("midrst_fb_addr", 32'(bus.fb_addr), 32'd0);
      check("midrst_fb_data", 32'(bus.fb_data), 32'd0);
      @(posedge pclk);
      #1;
      repeat (2) drive(1'b0, 1'b1, 8'h5A);
      rst_n = 1'b1;
      repeat (4) drive(1'b0, 1'b1, 8'hA5);
      repeat (4) drive(1'b0, 1'b0, 8'h00);
      wr_count = 0;
      repeat (3) send_line(1);
      check("midrst_no_writes", 32'(wr_count), 32'd0);
      vs_pulse();
      repeat (2) send_line(1);
      check("midrst_writes", 32'(wr_count), 32'd4);
      check("midrst_frame_done", 32'(fd_count), 32'(exp_fd));

      // vsync rises after only a high byte: no write, one frame_done.
      vs_pulse();
      wr_count = 0;
      send_line(0);
      drive(1'b0, 1'b1, 8'h84);
      vs_pulse();
      check("abort_writes", 32'(wr_count), 32'd4);
      check("abort_frame_done", 32'(fd_count), 32'(exp_fd));
      send_line(2);
      check("abort_next_mem0", 32'(mem[0]), 32'h0888);
      check("abort_next_addr", 32'(last_addr), 32'd3);
      vs_pulse();
      check("final_frame_done", 32'(fd_count), 32'(exp_fd));
      check("final_queue_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
